// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: byte-level register read/write command engine behind a UART.
// The host sends 'W' addr data, 'R' addr or '?'. Each command gets exactly one reply byte
// through the transmitter handshake. The register bank is exported to the rest of the design.
`timescale 1ns/1ps
module uart_cmd_responder #(
    parameter int clk_freq       = 125_000_000,
    parameter int NREGS          = 16,
    parameter int TIMEOUT_CYCLES = clk_freq / 100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 donerx,
    input  logic [7:0]           doutrx,
    input  logic                 donetx,
    output logic                 newd,
    output logic [7:0]           dintx,
    output logic [8*NREGS-1:0]   regs,
    output logic                 wr_strobe,
    output logic                 busy,
    output logic [7:0]           err_cnt
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] GET_ADDR = 3'd1;
    localparam logic [2:0] GET_DATA = 3'd2;
    localparam logic [2:0] EXEC     = 3'd3;
    localparam logic [2:0] SEND     = 3'd4;
    localparam logic [2:0] WAIT_TX  = 3'd5;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_PING  = 8'h3F;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h45;
    localparam logic [7:0] RSP_PING = 8'h55;

    // The counter never has to hold more than TIMEOUT_CYCLES-2, so this width is enough.
    // When the counter sits at TIMEOUT_CYCLES-2 its next value would be TIMEOUT_CYCLES-1,
    // which is the point where the partial command is abandoned.
    localparam int             TW           = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 2);
    localparam logic [8:0]     NREGS_W      = 9'(NREGS);

    logic [2:0]    state;
    logic [7:0]    opcode;
    logic [7:0]    addr;
    logic [7:0]    data;
    logic [TW-1:0] tcnt;
    logic [3:0]    idx;
    logic          addr_ok;
    logic          exec_err;
    logic          drop;
    logic          timeout;
    logic          err_event;
    logic [7:0]    reply;

    assign idx = addr[3:0];

    // Decode the latched command into a reply byte and collect every error source for this cycle.
    always_comb begin
        addr_ok  = ({1'b0, addr} < NREGS_W);
        reply    = RSP_ERR;
        exec_err = 1'b1;
        case (opcode)
            OP_WRITE: begin
                if (addr_ok) begin
                    reply    = RSP_OK;
                    exec_err = 1'b0;
                end
            end
            OP_READ: begin
                if (addr_ok) begin
                    reply    = regs[8*idx +: 8];
                    exec_err = 1'b0;
                end
            end
            OP_PING: begin
                reply    = RSP_PING;
                exec_err = 1'b0;
            end
            default: begin
            end
        endcase
        wr_strobe = (state == EXEC) && (opcode == OP_WRITE) && addr_ok;
        drop      = donerx && ((state == EXEC) || (state == SEND) || (state == WAIT_TX));
        timeout   = ((state == GET_ADDR) || (state == GET_DATA)) && !donerx && (tcnt == TIMEOUT_LAST);
        err_event = drop || timeout || ((state == EXEC) && exec_err);
        busy      = (state != IDLE);
    end

    // Command FSM, register bank, reply staging, inter-byte timeout and error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            opcode  <= 8'h00;
            addr    <= 8'h00;
            data    <= 8'h00;
            tcnt    <= '0;
            newd    <= 1'b0;
            dintx   <= 8'h00;
            regs    <= '0;
            err_cnt <= 8'h00;
        end else begin
            newd <= 1'b0;
            if (err_event && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
            if (wr_strobe) begin
                regs[8*idx +: 8] <= data;
            end
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (donerx) begin
                        opcode <= doutrx;
                        if ((doutrx == OP_WRITE) || (doutrx == OP_READ)) begin
                            state <= GET_ADDR;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                GET_ADDR: begin
                    if (donerx) begin
                        addr <= doutrx;
                        tcnt <= '0;
                        state <= (opcode == OP_WRITE) ? GET_DATA : EXEC;
                    end else if (timeout) begin
                        tcnt  <= '0;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                GET_DATA: begin
                    if (donerx) begin
                        data  <= doutrx;
                        tcnt  <= '0;
                        state <= EXEC;
                    end else if (timeout) begin
                        tcnt  <= '0;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                EXEC: begin
                    dintx <= reply;
                    newd  <= 1'b1;
                    state <= SEND;
                end
                SEND: begin
                    state <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (donetx) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb_uart_cmd_responder: directed scenarios for the UART register command responder.
`timescale 1ns/1ps
module tb_uart_cmd_responder;

    localparam int NREGS   = 16;
    localparam int TIMEOUT = 100;

    logic               clk = 1'b0;
    logic               rst;
    logic               donerx;
    logic [7:0]         doutrx;
    logic               donetx;
    logic               newd;
    logic [7:0]         dintx;
    logic [8*NREGS-1:0] regs;
    logic               wr_strobe;
    logic               busy;
    logic [7:0]         err_cnt;

    int total = 0;
    int bad   = 0;
    int newd_count = 0;
    int wr_count   = 0;

    always #5 clk = ~clk;

    uart_cmd_responder #(
        .NREGS(NREGS),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .donerx(donerx),
        .doutrx(doutrx),
        .donetx(donetx),
        .newd(newd),
        .dintx(dintx),
        .regs(regs),
        .wr_strobe(wr_strobe),
        .busy(busy),
        .err_cnt(err_cnt)
    );

    // Count newd and wr_strobe pulses on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (newd) newd_count++;
        if (wr_strobe) wr_count++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        doutrx = b;
        donerx = 1'b1;
        step();
        donerx = 1'b0;
        doutrx = 8'h00;
    endtask

    task automatic finish_tx();
        repeat (3) step();
        donetx = 1'b1;
        step();
        donetx = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Called in the cycle after the final command byte; returns what the transmitter saw.
    task automatic run_reply(output logic nd, output logic [7:0] dx);
        step();
        nd = newd;
        dx = dintx;
        step();
        finish_tx();
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (newd !== 1'b0) begin bad++; $display("[TB] FAIL reset_newd: got %b want 0", newd); end
        total++; if (dintx !== 8'h00) begin bad++; $display("[TB] FAIL reset_dintx: got %h want 00", dintx); end
        total++; if (regs !== '0) begin bad++; $display("[TB] FAIL reset_regs: got %h want 0", regs); end
        total++; if (wr_strobe !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr_strobe: got %b want 0", wr_strobe); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        total++; if (err_cnt !== 8'h00) begin bad++; $display("[TB] FAIL reset_err_cnt: got %h want 00", err_cnt); end
    endtask

    task automatic test_write_read();
        logic nd;
        logic [7:0] dx;
        send_byte(8'h57);
        send_byte(8'h03);
        send_byte(8'hA5);
        total++; if (wr_strobe !== 1'b1) begin bad++; $display("[TB] FAIL wr_strobe_n1: got %b want 1", wr_strobe); end
        total++; if (newd !== 1'b0) begin bad++; $display("[TB] FAIL newd_n1: got %b want 0", newd); end
        total++; if (regs[31:24] !== 8'h00) begin bad++; $display("[TB] FAIL reg3_n1: got %h want 00", regs[31:24]); end
        step();
        total++; if (newd !== 1'b1) begin bad++; $display("[TB] FAIL newd_n2: got %b want 1", newd); end
        total++; if (dintx !== 8'h4B) begin bad++; $display("[TB] FAIL write_reply: got %h want 4b", dintx); end
        total++; if (regs[31:24] !== 8'hA5) begin bad++; $display("[TB] FAIL reg3_n2: got %h want a5", regs[31:24]); end
        total++; if (wr_strobe !== 1'b0) begin bad++; $display("[TB] FAIL wr_strobe_n2: got %b want 0", wr_strobe); end
        step();
        total++; if (newd !== 1'b0) begin bad++; $display("[TB] FAIL newd_n3: got %b want 0", newd); end
        total++; if (dintx !== 8'h4B) begin bad++; $display("[TB] FAIL dintx_hold: got %h want 4b", dintx); end
        finish_tx();
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL busy_after_tx: got %b want 0", busy); end
        send_byte(8'h52);
        send_byte(8'h03);
        run_reply(nd, dx);
        total++; if (nd !== 1'b1) begin bad++; $display("[TB] FAIL read_newd: got %b want 1", nd); end
        total++; if (dx !== 8'hA5) begin bad++; $display("[TB] FAIL read_reply: got %h want a5", dx); end
    endtask

    task automatic test_bad_opcode();
        logic nd;
        logic [7:0] dx;
        logic [8*NREGS-1:0] exp_regs;
        exp_regs = '0;
        exp_regs[31:24] = 8'hA5;
        send_byte(8'h58);
        total++; if (wr_strobe !== 1'b0) begin bad++; $display("[TB] FAIL badop_wr_strobe: got %b want 0", wr_strobe); end
        run_reply(nd, dx);
        total++; if (dx !== 8'h45) begin bad++; $display("[TB] FAIL badop_reply: got %h want 45", dx); end
        total++; if (err_cnt !== 8'h01) begin bad++; $display("[TB] FAIL badop_err_cnt: got %h want 01", err_cnt); end
        send_byte(8'h3F);
        run_reply(nd, dx);
        total++; if (dx !== 8'h55) begin bad++; $display("[TB] FAIL ping_reply: got %h want 55", dx); end
        total++; if (err_cnt !== 8'h01) begin bad++; $display("[TB] FAIL ping_err_cnt: got %h want 01", err_cnt); end
        total++; if (regs !== exp_regs) begin bad++; $display("[TB] FAIL regs_unchanged: got %h want %h", regs, exp_regs); end
    endtask

    task automatic test_bad_addr();
        logic nd;
        logic [7:0] dx;
        int wr_base;
        apply_reset();
        wr_base = wr_count;
        send_byte(8'h57);
        send_byte(8'h10);
        send_byte(8'h77);
        run_reply(nd, dx);
        total++; if (dx !== 8'h45) begin bad++; $display("[TB] FAIL badaddr_reply: got %h want 45", dx); end
        total++; if (wr_count !== wr_base) begin bad++; $display("[TB] FAIL badaddr_wr_pulses: got %0d want %0d", wr_count, wr_base); end
        total++; if (err_cnt !== 8'h01) begin bad++; $display("[TB] FAIL badaddr_err_cnt: got %h want 01", err_cnt); end
        total++; if (regs !== '0) begin bad++; $display("[TB] FAIL badaddr_regs: got %h want 0", regs); end
    endtask

    task automatic test_timeout();
        logic nd;
        logic [7:0] dx;
        int nd_base;
        apply_reset();
        nd_base = newd_count;
        send_byte(8'h52);
        repeat (TIMEOUT - 2) step();
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL timeout_busy_c99: got %b want 1", busy); end
        total++; if (err_cnt !== 8'h00) begin bad++; $display("[TB] FAIL timeout_err_early: got %h want 00", err_cnt); end
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL timeout_busy_c100: got %b want 0", busy); end
        total++; if (err_cnt !== 8'h01) begin bad++; $display("[TB] FAIL timeout_err_cnt: got %h want 01", err_cnt); end
        total++; if (newd_count !== nd_base) begin bad++; $display("[TB] FAIL timeout_newd: got %0d want %0d", newd_count, nd_base); end
        send_byte(8'h52);
        send_byte(8'h00);
        run_reply(nd, dx);
        total++; if (nd !== 1'b1 || dx !== 8'h00) begin bad++; $display("[TB] FAIL timeout_next_read: got %b/%h want 1/00", nd, dx); end
    endtask

    task automatic test_back_to_back();
        logic nd;
        logic [7:0] dx;
        int nd_base;
        apply_reset();
        nd_base = newd_count;
        send_byte(8'h52);
        send_byte(8'h00);
        step();
        nd = newd;
        dx = dintx;
        total++; if (nd !== 1'b1 || dx !== 8'h00) begin bad++; $display("[TB] FAIL b2b_reply: got %b/%h want 1/00", nd, dx); end
        step();
        send_byte(8'h52);
        total++; if (err_cnt !== 8'h01) begin bad++; $display("[TB] FAIL b2b_drop_err: got %h want 01", err_cnt); end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_busy_wait: got %b want 1", busy); end
        finish_tx();
        repeat (5) step();
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_not_queued: got %b want 0", busy); end
        total++; if (newd_count - nd_base !== 1) begin bad++; $display("[TB] FAIL b2b_newd_count: got %0d want 1", newd_count - nd_base); end
    endtask

    task automatic test_simultaneous_errors();
        apply_reset();
        send_byte(8'h58);
        send_byte(8'h3F);
        total++; if (newd !== 1'b1 || dintx !== 8'h45) begin bad++; $display("[TB] FAIL simul_reply: got %b/%h want 1/45", newd, dintx); end
        total++; if (err_cnt !== 8'h01) begin bad++; $display("[TB] FAIL simul_err_once: got %h want 01", err_cnt); end
        step();
        finish_tx();
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL simul_busy: got %b want 0", busy); end
    endtask

    task automatic test_err_saturate();
        logic nd;
        logic [7:0] dx;
        apply_reset();
        for (int i = 0; i < 254; i++) begin
            send_byte(8'h00);
            run_reply(nd, dx);
        end
        total++; if (err_cnt !== 8'hFE) begin bad++; $display("[TB] FAIL sat_254: got %h want fe", err_cnt); end
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h00);
            run_reply(nd, dx);
        end
        total++; if (err_cnt !== 8'hFF) begin bad++; $display("[TB] FAIL sat_hold: got %h want ff", err_cnt); end
        total++; if (dx !== 8'h45) begin bad++; $display("[TB] FAIL sat_reply: got %h want 45", dx); end
    endtask

    task automatic test_reset_mid_command();
        logic nd;
        logic [7:0] dx;
        apply_reset();
        send_byte(8'h57);
        send_byte(8'h02);
        send_byte(8'h5A);
        run_reply(nd, dx);
        total++; if (regs[23:16] !== 8'h5A) begin bad++; $display("[TB] FAIL pre_rst_reg2: got %h want 5a", regs[23:16]); end
        send_byte(8'h57);
        send_byte(8'h02);
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_busy: got %b want 0", busy); end
        total++; if (regs !== '0) begin bad++; $display("[TB] FAIL rst_mid_regs: got %h want 0", regs); end
        total++; if (dintx !== 8'h00) begin bad++; $display("[TB] FAIL rst_mid_dintx: got %h want 00", dintx); end
        total++; if (newd !== 1'b0 || err_cnt !== 8'h00) begin bad++; $display("[TB] FAIL rst_mid_newd_err: got %b/%h want 0/00", newd, err_cnt); end
        send_byte(8'h52);
        send_byte(8'h02);
        run_reply(nd, dx);
        total++; if (nd !== 1'b1 || dx !== 8'h00) begin bad++; $display("[TB] FAIL rst_mid_read: got %b/%h want 1/00", nd, dx); end
    endtask

    initial begin
        rst    = 1'b1;
        donerx = 1'b0;
        donetx = 1'b0;
        doutrx = 8'h00;
        test_reset();
        test_write_read();
        test_bad_opcode();
        test_bad_addr();
        test_timeout();
        test_back_to_back();
        test_simultaneous_errors();
        test_err_saturate();
        test_reset_mid_command();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
